// File: rtl/axi_lite_bram_responder.sv
// rtl/axi_lite_bram_responder.sv - AXI4-Lite subordinate driving one port of a block RAM
module axi_lite_bram_responder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [ADDR_WIDTH-3:0] bram_addr,
  output logic [31:0]           bram_wrdata,
  input  logic [31:0]           bram_rddata
);

  typedef enum logic [2:0] {IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP} state_t;

  localparam int WAIT_LAST = (RAM_LATENCY > 1) ? RAM_LATENCY - 2 : 0;

  state_t                state, state_next;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           rdata_q;
  logic                  rdata_held;
  logic [1:0]            wait_cnt;
  logic                  wr_start;
  logic                  rd_start;
  logic                  unused_inputs;

  assign wr_start      = s_axi_awvalid & s_axi_wvalid;
  assign rd_start      = s_axi_arvalid & ~wr_start;
  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rresp   = 2'b00;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      rdata_held <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      if (state == IDLE) begin
        if (wr_start) begin
          addr_q  <= s_axi_awaddr[ADDR_WIDTH-1:2];
          wdata_q <= s_axi_wdata;
          wstrb_q <= s_axi_wstrb;
        end else if (rd_start) begin
          addr_q  <= s_axi_araddr[ADDR_WIDTH-1:2];
        end
      end
      wait_cnt <= (state == RD_WAIT) ? wait_cnt + 2'd1 : 2'd0;
      // RAM data is only valid in the first RD_RESP cycle; keep it for a stalled rready.
      if (state == RD_RESP) begin
        if (!rdata_held) begin
          rdata_q    <= bram_rddata;
          rdata_held <= 1'b1;
        end
      end else begin
        rdata_held <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (wr_start)           state_next = WR_EXEC;
        else if (s_axi_arvalid) state_next = RD_EXEC;
      end
      WR_EXEC: state_next = WR_RESP;
      WR_RESP: if (s_axi_bready) state_next = IDLE;
      RD_EXEC: state_next = (RAM_LATENCY == 1) ? RD_RESP : RD_WAIT;
      RD_WAIT: if (wait_cnt == 2'(WAIT_LAST)) state_next = RD_RESP;
      RD_RESP: if (s_axi_rready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rdata   = rdata_q;
    bram_en       = 1'b0;
    bram_we       = 4'h0;
    bram_addr     = '0;
    bram_wrdata   = '0;
    case (state)
      IDLE: begin
        s_axi_awready = wr_start;
        s_axi_wready  = wr_start;
        s_axi_arready = rd_start;
      end
      WR_EXEC: begin
        bram_en     = 1'b1;
        bram_we     = wstrb_q;
        bram_addr   = addr_q;
        bram_wrdata = wdata_q;
      end
      WR_RESP: s_axi_bvalid = 1'b1;
      RD_EXEC: begin
        bram_en   = 1'b1;
        bram_addr = addr_q;
      end
      RD_RESP: begin
        s_axi_rvalid = 1'b1;
        if (!rdata_held) s_axi_rdata = bram_rddata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_bram_responder.sv
// tb/tb_axi_lite_bram_responder.sv - scoreboard bench for axi_lite_bram_responder
module tb_axi_lite_bram_responder;

  localparam int AW  = 16;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-3:0] bram_addr;
  logic [31:0]   bram_wrdata, bram_rddata;

  int checks = 0;
  int failures = 0;
  logic [1:0]  b_q[$];
  logic [31:0] r_q[$];
  logic [31:0] ref_mem[int];

  always #5 clk = ~clk;

  axi_lite_bram_responder #(.ADDR_WIDTH(AW), .RAM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
  );

  // RAM with LAT-cycle read pipeline; idle cycles push noise so a mistimed capture is visible
  logic [31:0] mem [0:(1<<(AW-2))-1];
  logic [31:0] pipe [0:LAT-1];
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_wrdata[b*8 +: 8];
      pipe[0] <= mem[bram_addr];
    end else begin
      pipe[0] <= $urandom;
    end
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_rddata = pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
    int w = int'(a >> 2);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  function automatic void ref_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v = ref_read(a);
    for (int b = 0; b < 4; b++)
      if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
    ref_mem[int'(a >> 2)] = v;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (bvalid && bready) begin
        if (b_q.size() == 0) chk("unexpected_bresp", 1, 0);
        else chk("bresp", bresp, b_q.pop_front());
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) chk("unexpected_rdata", 1, 0);
        else chk("rdata_rresp", {rresp, rdata}, {2'b00, r_q.pop_front()});
      end
    end
  end

  task automatic wait_drained(input string name);
    int n;
    for (n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (b_q.size() == 0 && r_q.size() == 0) break;
    end
    chk(name, n < 20, 1);
  endtask

  task automatic write_txn(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
    int n;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awprot = 3'($urandom); awvalid = 1; wvalid = 1;
    bready = (hold == 0);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (awready && wready) break;
    end
    chk("aw_accept", n < 20, 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = (hold > 0); araddr = 16'h0004;
    ref_write(a, d, s);
    b_q.push_back(2'b00);
    @(negedge clk);
    chk("wr_exec_port", {bram_en, bram_we, bram_addr, bram_wrdata, arready}, {1'b1, s, a[AW-1:2], d, 1'b0});
    @(negedge clk);
    chk("bvalid_latency", bvalid, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("b_hold", {bvalid, bresp, awready, wready, arready, bram_en}, 7'b1000000);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      arvalid = 0; bready = 1;
    end
    wait_drained("b_done");
  endtask

  task automatic read_txn(input logic [AW-1:0] a, input int hold);
    int n;
    logic [31:0] exp = ref_read(a);
    @(posedge clk); #1;
    araddr = a; arprot = 3'($urandom); arvalid = 1; rready = (hold == 0);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (arready) break;
    end
    chk("ar_accept", n < 20, 1);
    @(posedge clk); #1;
    arvalid = 0; awvalid = (hold > 0); wvalid = (hold > 0); awaddr = 16'h0008; wstrb = 4'hF;
    r_q.push_back(exp);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 0) chk("rd_exec_port", {bram_en, bram_we, bram_addr}, {1'b1, 4'h0, a[AW-1:2]});
      if (rvalid) break;
    end
    chk("r_latency", n, LAT);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("r_hold", {rvalid, awready, wready, arready, bram_en, rdata}, {5'b10000, exp});
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0; rready = 1;
    end
    wait_drained("r_done");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata,
                          bram_en, bram_we, bram_addr, bram_wrdata}, '0);
    @(posedge clk); #1 reset = 0;

    write_txn(16'h0010, 32'hDEADBEEF, 4'hF, 0);
    read_txn(16'h0010, 0);
    write_txn(16'h0040, 32'h11223344, 4'hF, 0);
    write_txn(16'h0041, 32'h0000AB00, 4'b0010, 0);
    read_txn(16'h0040, 0);
    write_txn(16'h0042, 32'hFFFFFFFF, 4'h0, 0);
    read_txn(16'h0043, 0);
    write_txn(16'h0030, 32'hCAFEF00D, 4'hF, 5);
    read_txn(16'h0030, 5);

    // simultaneous AW/W/AR to the same word: write first, read sees new data
    @(posedge clk); #1;
    awaddr = 16'h0020; wdata = 32'h5A5AA5A5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 16'h0020; arvalid = 1; bready = 0;
    @(negedge clk);
    chk("tie_write_wins", {awready, wready, arready}, 3'b110);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    ref_write(16'h0020, 32'h5A5AA5A5, 4'hF);
    b_q.push_back(2'b00);
    repeat (3) begin
      @(negedge clk);
      chk("tie_ar_stalled", arready, 0);
    end
    @(posedge clk); #1;
    bready = 1;
    r_q.push_back(ref_read(16'h0020));
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (arready) break;
    end
    chk("tie_ar_accept", n < 20, 1);
    chk("tie_b_before_ar", b_q.size(), 0);
    @(posedge clk); #1 arvalid = 0;
    wait_drained("tie_r_done");

    // reset while waiting on RAM latency
    @(posedge clk); #1;
    araddr = 16'h0010; arvalid = 1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (arready) break;
    end
    chk("rst_ar_accept", n < 20, 1);
    @(posedge clk); #1 arvalid = 0;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rst_mid_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata,
                            bram_en, bram_we, bram_addr, bram_wrdata}, '0);
    repeat (4) begin
      @(negedge clk);
      chk("rst_quiet", {rvalid, bram_en}, 2'b00);
    end
    write_txn(16'h0050, 32'h0BADCAFE, 4'hF, 0);
    read_txn(16'h0050, 1);

    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a = 16'h0100 + AW'({$urandom_range(0, 7), 2'($urandom)});
      if (ref_mem.exists(int'(a >> 2)) && $urandom_range(0, 1) == 1)
        read_txn(a, $urandom_range(0, 2));
      else
        write_txn(a, $urandom, 4'($urandom), $urandom_range(0, 2));
    end

    chk("queues_empty", b_q.size() + r_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
